// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream input plus instruction-memory write port of the
//               program loader.
// Revision    : 1.0
// ============================================================================
interface program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 15
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [WORD_W-1:0] im_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    // Source/memory side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Fills instruction memory from a byte stream, verifies an XOR
//               checksum and releases the CPU once the load is complete.
// Revision    : 1.0
// ============================================================================
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 15
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    program_loader_if.slave        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   cpu_run,
    output logic [ADDR_W:0]        word_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_WR   = 3'd4,
        S_CSUM = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t            state_q,    state_d;
    logic [7:0]        n_q,        n_d;
    logic [6:0]        hi_q,       hi_d;
    logic [7:0]        chk_q,      chk_d;
    logic              err_q,      err_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic [WORD_W-1:0] wdata_q,    wdata_d;
    logic              we_q,       we_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              cpu_run_q,  cpu_run_d;

    logic              xfer;
    logic [ADDR_W:0]   count_inc;

    assign xfer      = bus.in_valid && in_ready_q;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hi_d    = hi_q;
        chk_d   = chk_q;
        err_d   = err_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEN;
                    count_d = '0;
                    addr_d  = '0;
                    chk_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    n_d     = bus.in_data;
                    chk_d   = bus.in_data;
                    state_d = (bus.in_data == 8'd0) ? S_CSUM : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    // Opcode MSB is dropped from the word but still checksummed.
                    hi_d    = bus.in_data[6:0];
                    chk_d   = chk_q ^ bus.in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    chk_d   = chk_q ^ bus.in_data;
                    wdata_d = {hi_q, bus.in_data};
                    we_d    = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // Write strobe is active this cycle; advance past the word.
                addr_d  = addr_q + 1'b1;
                count_d = count_inc;
                state_d = (count_inc == (ADDR_W+1)'(n_q)) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (xfer) begin
                    err_d   = (bus.in_data != chk_q);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they change
        // on the same edge as the state itself.
        in_ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
                     (state_d == S_LO)  || (state_d == S_CSUM);
        busy_d     = in_ready_d || (state_d == S_WR);
        done_d     = (state_d == S_DONE);
        cpu_run_d  = done_d && !err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            hi_q       <= '0;
            chk_q      <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            count_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            hi_q       <= hi_d;
            chk_q      <= chk_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cpu_run_q  <= cpu_run_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_run      = cpu_run_q;
    assign word_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed and randomized loads checked against a word-list
//               reference model and a memory scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_program_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic       cpu_run;
    logic [8:0] word_count;

    int checks;
    int errors;
    int we_total;

    logic [14:0] mem [0:255];
    logic [15:0] wq [$];

    program_loader_if #(.ADDR_W(8), .WORD_W(15)) bus ();

    program_loader #(.ADDR_W(8), .WORD_W(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_run    (cpu_run),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory scoreboard: whatever the loader writes lands here.
    initial we_total = 0;
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            mem[bus.im_addr] <= bus.im_wdata;
            we_total         <= we_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stall for `stalls` cycles (optionally pulsing start), then hand over b.
    task automatic send_byte(input logic [7:0] b, input int stalls, input bit mid_start);
        int guard;
        for (int s = 0; s < stalls; s++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            start        = (mid_start && s == 1);
            tick();
        end
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard        = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            guard++;
            if (guard > 50) begin
                check("ready_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    function automatic int rstall(input int max_stall);
        return (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
    endfunction

    // Streams wq as one program; bad_mask corrupts the checksum byte.
    task automatic load(input logic [7:0] bad_mask, input int max_stall,
                        input int lo_stall, input bit mid_start);
        logic [7:0]  n;
        logic [7:0]  xsum;
        logic [7:0]  cs;
        logic [14:0] word;
        int          base;
        int          st;

        n    = 8'(wq.size());
        xsum = n;
        foreach (wq[i]) xsum = xsum ^ wq[i][15:8] ^ wq[i][7:0];
        cs   = xsum ^ bad_mask;
        base = we_total;

        pulse_start();
        check("start_busy",    32'(busy),       32'd1);
        check("start_ready",   32'(bus.in_ready), 32'd1);
        check("start_done",    32'(done),       32'd0);
        check("start_cpu_run", 32'(cpu_run),    32'd0);
        check("start_count",   32'(word_count), 32'd0);
        check("start_addr",    32'(bus.im_addr), 32'd0);

        send_byte(n, rstall(max_stall), 1'b0);
        foreach (wq[i]) begin
            send_byte(wq[i][15:8], rstall(max_stall), 1'b0);
            st = rstall(max_stall);
            if (lo_stall > st) st = lo_stall;
            send_byte(wq[i][7:0], st, mid_start);
            word = {wq[i][14:8], wq[i][7:0]};
            check("wr_we",    32'(bus.im_we),    32'd1);
            check("wr_addr",  32'(bus.im_addr),  32'(i));
            check("wr_data",  32'(bus.im_wdata), 32'(word));
            check("wr_ready", 32'(bus.in_ready), 32'd0);
            check("wr_busy",  32'(busy),         32'd1);
            tick();
            check("post_we",    32'(bus.im_we),    32'd0);
            check("post_addr",  32'(bus.im_addr),  32'(i + 1));
            check("post_count", 32'(word_count),   32'(i + 1));
            check("hold_data",  32'(bus.im_wdata), 32'(word));
        end
        send_byte(cs, rstall(max_stall), 1'b0);
        check("end_done",    32'(done),           32'd1);
        check("end_busy",    32'(busy),           32'd0);
        check("end_err",     32'(err),            32'(cs != xsum));
        check("end_cpu_run", 32'(cpu_run),        32'(cs == xsum));
        check("end_count",   32'(word_count),     32'(n));
        check("end_addr",    32'(bus.im_addr),    32'(n));
        check("end_ready",   32'(bus.in_ready),   32'd0);
        tick();
        check("we_pulses",   32'(we_total - base), 32'(n));
        foreach (wq[i]) check("mem", 32'(mem[i]), 32'({wq[i][14:8], wq[i][7:0]}));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_we"},    32'(bus.im_we),    32'd0);
        check({tag, "_addr"},  32'(bus.im_addr),  32'd0);
        check({tag, "_wdata"}, 32'(bus.im_wdata), 32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_done"},  32'(done),         32'd0);
        check({tag, "_err"},   32'(err),          32'd0);
        check({tag, "_run"},   32'(cpu_run),      32'd0);
        check({tag, "_count"}, 32'(word_count),   32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(bus.in_ready), 32'd0);

        // Two words, good then bad checksum (0x07 vs 0x08).
        wq = '{16'h0105, 16'h0203};
        load(8'h00, 0, 0, 1'b0);
        load(8'h0F, 0, 0, 1'b0);

        // Empty program, good and bad checksum.
        wq = {};
        load(8'h00, 0, 0, 1'b0);
        load(8'hFF, 0, 0, 1'b0);

        // Five-cycle stall before each LO byte with a stray start pulse.
        wq = '{16'h0105, 16'h0203};
        load(8'h00, 0, 5, 1'b1);

        // Opcode MSB dropped from the word but kept in the checksum.
        wq = '{16'h8510};
        load(8'h00, 0, 0, 1'b0);

        // Randomized programs with random stalls and occasional bad checksums.
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = int'($urandom_range(0, 12));
            wq = {};
            for (int k = 0; k < nw; k++) wq.push_back(16'($urandom));
            load(($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
                 int'($urandom_range(0, 3)), 0, 1'b0);
        end

        // Largest program: 255 words, addresses never wrap.
        wq = {};
        for (int k = 0; k < 255; k++) wq.push_back(16'($urandom));
        load(8'h00, 0, 0, 1'b0);

        // Reset in the middle of an N=3 load.
        pulse_start();
        send_byte(8'd3, 0, 1'b0);
        send_byte(8'h2A, 0, 1'b0);
        send_byte(8'h5C, 0, 1'b0);
        check("pre_rst_we", 32'(bus.im_we), 32'd1);
        tick();
        send_byte(8'h11, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("kept_mem0", 32'(mem[0]), 32'h2A5C);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wq = '{16'h7E01};
        load(8'h00, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
